// File: rtl/bbs_pkg.sv
// Shared types, default constants and the modular-reduction helper for the
// Blum-Blum-Shub stream generator.
package bbs_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    CAPT
  } bbs_state_t;

  // Default modulus (p*q with p, q = 3 mod 4) and default reset seed.
  localparam longint unsigned BBS_DEF_MOD  = 64'd40633;
  localparam longint unsigned BBS_DEF_SEED = 64'd884;

  // Widest state supported; keeps the WIDTH+1-bit intermediates inside the
  // 64-bit helper below.
  localparam int BBS_MAX_WIDTH = 62;

  // Single conditional subtract. Valid as a full reduction only when the
  // operand is already below 2*m, which the squarer guarantees.
  function automatic logic [63:0] bbs_cond_sub(input logic [63:0] a,
                                               input logic [63:0] m);
    return (a >= m) ? (a - m) : a;
  endfunction

endpackage

// File: rtl/bbs_modsq_seq.sv
// Iterative shift-add modular squarer: sq = x*x mod MOD, one multiplier bit
// per clock, MSB first. go clears the accumulator and arms WIDTH steps.
// ready flags the final multiplier bit; the step taken while busy && ready
// completes sq, which then holds until the next go.
module bbs_modsq_seq
  import bbs_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter longint unsigned MOD   = BBS_DEF_MOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] sq
);

  localparam int          IDX_W  = $clog2(WIDTH);
  localparam logic [63:0] MOD_64 = 64'(MOD);

  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic             run;

  logic [WIDTH-1:0] acc_dbl;
  logic [WIDTH:0]   acc_add;
  logic [WIDTH-1:0] acc_nxt;

  // One Horner step: acc = (2*acc mod MOD + x[idx]*x) mod MOD, computed in
  // WIDTH+1 bits so neither the doubling nor the addition can overflow.
  // NOTE: every always_comb output is a pure function of its inputs and is
  // assigned on every path, so no latch can be inferred.
  always_comb begin
    acc_dbl = WIDTH'(bbs_cond_sub(64'({acc, 1'b0}), MOD_64));
    acc_add = {1'b0, acc_dbl} + (x[idx] ? {1'b0, x} : '0);
    acc_nxt = WIDTH'(bbs_cond_sub(64'(acc_add), MOD_64));
  end

  // Accumulator and bit index; go restarts, otherwise step while running.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      idx <= '0;
      run <= 1'b0;
    end else if (go) begin
      acc <= '0;
      idx <= IDX_W'(WIDTH - 1);
      run <= 1'b1;
    end else if (run) begin
      acc <= acc_nxt;
      if (idx == '0) begin
        run <= 1'b0;
      end else begin
        idx <= idx - 1'b1;
      end
    end
  end

  assign busy  = run;
  assign ready = (idx == '0);
  assign sq    = acc;

endmodule

// File: rtl/bbs_stream_gen.sv
// Blum-Blum-Shub bit-stream generator. Each start produces OUT_BITS bits,
// one per squaring x <= x*x mod MOD, shifted into result MSB-first.
// Optional build macro BBS_PARITY_EN: output bit is the parity of the new x
// instead of its LSB; the state sequence is the same either way.
module bbs_stream_gen
  import bbs_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter longint unsigned MOD      = BBS_DEF_MOD,
  parameter longint unsigned SEED     = BBS_DEF_SEED,
  parameter int              OUT_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  output logic                busy,
  output logic                done,
  output logic                seed_err,
  output logic [OUT_BITS-1:0] result,
  output logic [WIDTH-1:0]    state_x
);

  // Reject impossible configurations at elaboration.
  if (WIDTH < 2 || WIDTH > BBS_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "bbs_stream_gen: WIDTH out of range");
  end
  if (MOD <= 64'd2 || MOD >= (64'd1 << WIDTH)) begin : g_bad_mod
    $fatal(1, "bbs_stream_gen: MOD must satisfy 2 < MOD < 2**WIDTH");
  end
  if (SEED < 64'd2 || SEED >= MOD) begin : g_bad_seed
    $fatal(1, "bbs_stream_gen: SEED must satisfy 2 <= SEED < MOD");
  end
  if (OUT_BITS < 1) begin : g_bad_out
    $fatal(1, "bbs_stream_gen: OUT_BITS must be at least 1");
  end

  localparam int                CNT_W    = $clog2(OUT_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OUT_BITS - 1);
  localparam logic [WIDTH:0]    MOD_W    = MOD[WIDTH:0];
  localparam logic [WIDTH-1:0]  SEED_X   = SEED[WIDTH-1:0];

  bbs_state_t          state_q, state_d;
  logic [WIDTH-1:0]    x_q;
  logic [CNT_W-1:0]    count;
  logic                seed_ok;
  logic                out_bit;
  logic [OUT_BITS-1:0] result_shift;

  logic                mod_go;
  logic                mod_busy;
  logic                mod_ready;
  logic [WIDTH-1:0]    mod_sq;

  bbs_modsq_seq #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_modsq (
    .clk   (clk),
    .reset (reset),
    .go    (mod_go),
    .x     (x_q),
    .busy  (mod_busy),
    .ready (mod_ready),
    .sq    (mod_sq)
  );

  // A seed is usable only inside [2, MOD); 0 and 1 are fixed points.
  assign seed_ok = (seed_in >= WIDTH'(2)) && ({1'b0, seed_in} < MOD_W);

`ifdef BBS_PARITY_EN
  assign out_bit = ^mod_sq;
`else
  assign out_bit = mod_sq[0];
`endif

  if (OUT_BITS == 1) begin : g_one_bit
    assign result_shift = out_bit;
  end else begin : g_multi_bit
    assign result_shift = {result[OUT_BITS-2:0], out_bit};
  end

  assign mod_go  = (state_q == LOAD);
  assign state_x = x_q;

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one LOAD, WIDTH ITER steps and one CAPT per generated bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (mod_busy && mod_ready) state_d = CAPT;
      CAPT:    state_d = (count == CNT_LAST) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Seed handling, run bookkeeping and capture of each squared state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= SEED_X;
      result   <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      seed_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seed_load) begin
            if (seed_ok) begin
              x_q <= seed_in;
            end else begin
              seed_err <= 1'b1;
            end
          end
          if (start) begin
            result <= '0;
            count  <= '0;
            busy   <= 1'b1;
          end
        end
        CAPT: begin
          x_q    <= mod_sq;
          result <= result_shift;
          count  <= count + 1'b1;
          if (count == CNT_LAST) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bbs_stream_gen.sv
// Directed bench for bbs_stream_gen with OUT_BITS=4 and the default modulus
// and seed. Inputs change and outputs are sampled on the falling edge.
module tb_bbs_stream_gen;

  localparam int WIDTH      = 16;
  localparam int OUT_BITS   = 4;
  localparam int RUN_CYCLES = OUT_BITS * (WIDTH + 2);
  localparam int TIMEOUT    = 1000;

  // x: 884 -> 9429 -> 1037 -> 18911 -> 14888 -> 40162 -> 18676 -> 39937 -> 37453
`ifdef BBS_PARITY_EN
  localparam logic [OUT_BITS-1:0] EXP_RUN1 = 4'b1000;
  localparam logic [OUT_BITS-1:0] EXP_RUN2 = 4'b0111;
`else
  localparam logic [OUT_BITS-1:0] EXP_RUN1 = 4'b1110;
  localparam logic [OUT_BITS-1:0] EXP_RUN2 = 4'b0011;
`endif

  logic                clk;
  logic                reset;
  logic                start;
  logic                seed_load;
  logic [WIDTH-1:0]    seed_in;
  logic                busy;
  logic                done;
  logic                seed_err;
  logic [OUT_BITS-1:0] result;
  logic [WIDTH-1:0]    state_x;

  int n_checks;
  int n_errors;
  int lat;
  int busy_cycles;
  int err_cycles;

  typedef struct {
    logic [WIDTH-1:0] seed;
    logic             exp_err;
    logic [WIDTH-1:0] exp_x;
  } seed_vec_t;

  seed_vec_t seed_tbl [7];

  bbs_stream_gen #(
    .WIDTH    (WIDTH),
    .MOD      (64'd40633),
    .SEED     (64'd884),
    .OUT_BITS (OUT_BITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .busy      (busy),
    .done      (done),
    .seed_err  (seed_err),
    .result    (result),
    .state_x   (state_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse start (optionally with a seed), then count falling edges until done.
  // lat is the number of rising edges after the one that sampled start.
  // inject_at >= 0 pulses start+seed_load(5) mid-run; stop_at >= 0 returns
  // early once lat reaches that value.
  task automatic run_wait(input bit with_seed, input logic [WIDTH-1:0] seed,
                          input int inject_at, input int stop_at,
                          output int lat_o, output int busy_o,
                          output int err_o);
    start     = 1'b1;
    seed_load = with_seed;
    seed_in   = seed;
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
    lat_o  = 0;
    busy_o = 0;
    err_o  = 0;
    while (!done && lat_o < TIMEOUT && lat_o != stop_at) begin
      if (busy) busy_o++;
      if (seed_err) err_o++;
      start     = (lat_o == inject_at);
      seed_load = (lat_o == inject_at);
      seed_in   = 16'd5;
      @(negedge clk);
      lat_o++;
    end
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;

    seed_tbl[0] = '{seed: 16'd40633, exp_err: 1'b1, exp_x: 16'd37453};
    seed_tbl[1] = '{seed: 16'd1,     exp_err: 1'b1, exp_x: 16'd37453};
    seed_tbl[2] = '{seed: 16'd0,     exp_err: 1'b1, exp_x: 16'd37453};
    seed_tbl[3] = '{seed: 16'd65535, exp_err: 1'b1, exp_x: 16'd37453};
    seed_tbl[4] = '{seed: 16'd2,     exp_err: 1'b0, exp_x: 16'd2};
    seed_tbl[5] = '{seed: 16'd40632, exp_err: 1'b0, exp_x: 16'd40632};
    seed_tbl[6] = '{seed: 16'd884,   exp_err: 1'b0, exp_x: 16'd884};

    repeat (3) @(negedge clk);
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_done",     64'(done),     64'd0);
    check("rst_seed_err", 64'(seed_err), 64'd0);
    check("rst_result",   64'(result),   64'd0);
    check("rst_state_x",  64'(state_x),  64'd884);
    reset = 1'b0;
    @(negedge clk);

    // First run from the reset seed.
    run_wait(1'b0, '0, -1, -1, lat, busy_cycles, err_cycles);
    check("run1_latency", 64'(lat),         64'(RUN_CYCLES));
    check("run1_busy",    64'(busy_cycles), 64'(RUN_CYCLES));
    check("run1_done",    64'(done),        64'd1);
    check("run1_idle",    64'(busy),        64'd0);
    check("run1_result",  64'(result),      64'(EXP_RUN1));
    check("run1_state_x", 64'(state_x),     64'd14888);
    @(negedge clk);
    check("run1_done_pulse", 64'(done),   64'd0);
    check("run1_hold",       64'(result), 64'(EXP_RUN1));

    // Second run continues the sequence from 14888.
    run_wait(1'b0, '0, -1, -1, lat, busy_cycles, err_cycles);
    check("run2_latency", 64'(lat),     64'(RUN_CYCLES));
    check("run2_result",  64'(result),  64'(EXP_RUN2));
    check("run2_state_x", 64'(state_x), 64'd37453);
    @(negedge clk);

    // Seed validation vectors.
    for (int i = 0; i < 7; i++) begin
      seed_load = 1'b1;
      seed_in   = seed_tbl[i].seed;
      @(negedge clk);
      seed_load = 1'b0;
      check($sformatf("seed%0d_err", i),   64'(seed_err), 64'(seed_tbl[i].exp_err));
      check($sformatf("seed%0d_x", i),     64'(state_x),  64'(seed_tbl[i].exp_x));
      @(negedge clk);
      check($sformatf("seed%0d_clear", i), 64'(seed_err), 64'd0);
    end

    // start and seed_load during a run must be ignored.
    run_wait(1'b0, '0, 30, -1, lat, busy_cycles, err_cycles);
    check("inject_latency",  64'(lat),        64'(RUN_CYCLES));
    check("inject_result",   64'(result),     64'(EXP_RUN1));
    check("inject_state_x",  64'(state_x),    64'd14888);
    check("inject_seed_err", 64'(err_cycles), 64'd0);
    @(negedge clk);
    check("inject_no_rerun", 64'(busy), 64'd0);

    // seed_load together with start: the run uses the new seed.
    run_wait(1'b1, 16'd884, -1, -1, lat, busy_cycles, err_cycles);
    check("combo_latency", 64'(lat),     64'(RUN_CYCLES));
    check("combo_result",  64'(result),  64'(EXP_RUN1));
    check("combo_state_x", 64'(state_x), 64'd14888);
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    run_wait(1'b1, 16'd884, -1, 40, lat, busy_cycles, err_cycles);
    check("mid_busy",    64'(busy),    64'd1);
    check("mid_state_x", 64'(state_x), 64'd1037);
    reset = 1'b1;
    #1;
    check("arst_busy",    64'(busy),    64'd0);
    check("arst_done",    64'(done),    64'd0);
    check("arst_result",  64'(result),  64'd0);
    check("arst_state_x", 64'(state_x), 64'd884);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_wait(1'b0, '0, -1, -1, lat, busy_cycles, err_cycles);
    check("post_rst_latency", 64'(lat),     64'(RUN_CYCLES));
    check("post_rst_result",  64'(result),  64'(EXP_RUN1));
    check("post_rst_state_x", 64'(state_x), 64'd14888);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bbs_stream_gen.md
Name: bbs_stream_gen

Overview:
- Parametrised Blum-Blum-Shub bit-stream generator.
- Successor to the fixed 16-bit/256-bit number generator.
- Replaces the single-cycle combinational modular multiplier with an iterative shift-add modular squarer (one multiplier bit per clock).
- Adds seed loading with validation, a start/busy/done handshake, and configurable modulus, state width and output length.
- Sits between the button handlers (start, seed_load pulses) and the display/readout logic, which consumes result when done pulses.

Parameters:
- WIDTH, 16: state/modulus width in bits.
- MOD, 40633: BBS modulus. Constraints: 2 < MOD < 2**WIDTH; violation is a fatal elaboration error.
- SEED, 884: reset value of the internal state x. Constraint: 2 <= SEED < MOD.
- OUT_BITS, 256: number of generated bits per run, i.e. the result width. Constraint: OUT_BITS >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; requests one run of OUT_BITS bits.
- seed_load  in  1  single-cycle pulse; load seed_in into x.
- seed_in  in  WIDTH  candidate seed.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when result is complete.
- seed_err  out  1  one-cycle pulse when a seed is rejected.
- result  out  OUT_BITS  generated bits; the first generated bit is at the MSB.
- state_x  out  WIDTH  current BBS state x.

Behaviour:
- Reset, asynchronous and taking effect immediately, including mid-run:
  - FSM goes to IDLE.
  - busy=0, done=0, seed_err=0, result=0, x=SEED, bit counter=0.
- FSM states: IDLE, LOAD, ITER, CAPT.
- IDLE:
  - seed_load=1 and 2 <= seed_in < MOD: x <= seed_in.
  - seed_load=1 and seed_in invalid: x unchanged; seed_err pulses the next cycle.
  - start=1: result <= 0, count <= 0, busy <= 1, go to LOAD.
  - seed_load and start together: both are accepted, and the run uses the newly loaded seed if it is valid.
- LOAD (1 cycle): acc <= 0, idx <= WIDTH-1, go to ITER.
- ITER (WIDTH cycles), each cycle:
  - acc <= (2*acc) mod MOD, then acc <= (acc + x[idx]*x) mod MOD.
  - Each reduction is a single conditional subtract.
  - acc is WIDTH+1 bits internally, so no overflow is possible.
  - After idx=0, go to CAPT.
- CAPT (1 cycle):
  - x <= acc, which equals x*x mod MOD.
  - result <= {result[OUT_BITS-2:0], b}, where b = acc[0].
  - count <= count+1.
  - If count == OUT_BITS-1: busy <= 0, done pulses, go to IDLE. Otherwise go to LOAD.
- Timing: each bit costs WIDTH+2 cycles (LOAD + WIDTH×ITER + CAPT). done is high exactly OUT_BITS*(WIDTH+2) cycles after the cycle in which start was sampled.
- result and state_x are stable while busy=0. state_x persists across runs, so consecutive runs continue the same sequence.
- start and seed_load while busy=1: ignored, with no error flag.
- count width is $clog2(OUT_BITS+1). The OUT_BITS=1 case must work; result is then a single bit.

Optional Feature:
- Macro: BBS_PARITY_EN.
- Defined: the output bit b = XOR-reduction of the new x (parity bit extraction).
- Undefined: b = new x[0].
- The state sequence is identical either way; only result differs.

Decomposition:
- Package bbs_pkg:
  - FSM state enum (IDLE, LOAD, ITER, CAPT).
  - Default constants BBS_DEF_MOD=40633 and BBS_DEF_SEED=884.
  - Function for the conditional-subtract modular reduction.
- Sub-module bbs_modsq_seq: the iterative modular squarer.
  - Ports: clk, reset, go, x, busy, ready, sq.
  - Top FSM drives go for one cycle and captures sq when ready.

Test Plan:
- Defaults except OUT_BITS=4; reset; pulse start → busy high for 72 cycles; done pulses at cycle 72; result=4'b1110; state_x=14888 (x sequence 9429, 1037, 18911, 14888).
- Continue from the previous state; pulse start again → the next run continues from x=14888 (first new x=14888² mod 40633), not from 884.
- seed_load with seed_in=40633, then seed_in=1 → seed_err pulses each time and state_x stays unchanged; seed_in=884 → state_x=884, no seed_err.
- Mid-run at cycle 30: pulse start and seed_load → ignored; done still arrives at cycle 72 with result=4'b1110.
- Assert reset at cycle 40 of a run → immediately busy=0, result=0, state_x=884; a following start reproduces 4'b1110.
- With BBS_PARITY_EN defined, OUT_BITS=1, seed 884 → x=9429 (seven ones), result=1'b1, done after 18 cycles.
